// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache between the EX_MEM stage
// and a line-wide data memory. Round-robin victims with invalid-way preference.
module dcache_assoc #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF - IDX;
  localparam int WSEL  = $clog2(LINE_W / WORD_W);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WB_REQ, RF_REQ, RF_DONE} state_t;
  state_t state_reg, state_next;

  logic              valid_reg [SETS][WAYS];
  logic              dirty_reg [SETS][WAYS];
  logic [TAG_W-1:0]  tag_reg   [SETS][WAYS];
  logic [LINE_W-1:0] data_reg  [SETS][WAYS];
  logic [WAY_W-1:0]  ptr_reg   [SETS];

  logic [WAY_W-1:0]  vic_way_reg;
  logic [IDX-1:0]    vic_idx_reg;
  logic [TAG_W-1:0]  new_tag_reg;
  logic              vic_ptr_reg;
  logic              mem_enable_reg, mem_write_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [LINE_W-1:0] mem_data_reg;
  logic [CNT_W-1:0]  hit_cnt_reg, miss_cnt_reg;
  logic [WORD_W-1:0] p1_data_reg;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX-1:0]    req_idx;
  logic [WSEL-1:0]   req_word;
  logic              req, wr, rd, hit, hit_ok, miss_start, vic_dirty, victim_from_ptr;
  logic [WAYS-1:0]   way_hit;
  logic [WAY_W-1:0]  hit_way, victim;
  logic [LINE_W-1:0] hit_line;
  logic [WORD_W-1:0] hit_word;
  logic              unused_bits;

  assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx     = p1_addr_i[OFF +: IDX];
  assign req_word    = p1_addr_i[OFF-1 -: WSEL];
  assign unused_bits = &{1'b0, p1_addr_i[OFF-WSEL-1:0]};

  // A simultaneous read and write is a store.
  assign wr  = p1_MemWrite_i;
  assign rd  = p1_MemRead_i & ~p1_MemWrite_i;
  assign req = p1_MemRead_i | p1_MemWrite_i;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign way_hit[gi] = valid_reg[req_idx][gi] && (tag_reg[req_idx][gi] == req_tag);
  end

  assign hit = |way_hit;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_way = WAY_W'(w);
  end

  // Descending scan so the lowest-numbered invalid way wins over the pointer.
  always_comb begin
    victim          = ptr_reg[req_idx];
    victim_from_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_reg[req_idx][w]) begin
        victim          = WAY_W'(w);
        victim_from_ptr = 1'b0;
      end
    end
  end

  assign hit_line   = data_reg[req_idx][hit_way];
  assign hit_word   = hit_line[req_word*WORD_W +: WORD_W];
  assign vic_dirty  = valid_reg[req_idx][victim] & dirty_reg[req_idx][victim];
  assign hit_ok     = (state_reg == IDLE) & req & hit;
  assign miss_start = (state_reg == IDLE) & req & ~hit;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (miss_start) state_next = vic_dirty ? WB_REQ : RF_REQ;
      WB_REQ:  if (mem_ack_i) state_next = RF_REQ;
      RF_REQ:  if (mem_ack_i) state_next = RF_DONE;
      RF_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        ptr_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_reg[s][w] <= 1'b0;
          dirty_reg[s][w] <= 1'b0;
        end
      end
      vic_way_reg    <= '0;
      vic_idx_reg    <= '0;
      new_tag_reg    <= '0;
      vic_ptr_reg    <= 1'b0;
      mem_enable_reg <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
      p1_data_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      mem_enable_reg <= (state_next == WB_REQ) || (state_next == RF_REQ);
      mem_write_reg  <= (state_next == WB_REQ);
      if (hit_ok) begin
        if (wr) dirty_reg[req_idx][hit_way] <= 1'b1;
        if (rd) p1_data_reg <= hit_word;
        if (hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + 1'b1;
      end
      if (miss_start) begin
        vic_way_reg <= victim;
        vic_idx_reg <= req_idx;
        new_tag_reg <= req_tag;
        vic_ptr_reg <= victim_from_ptr;
        if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + 1'b1;
        if (vic_dirty) begin
          mem_addr_reg <= {tag_reg[req_idx][victim], req_idx, {OFF{1'b0}}};
          mem_data_reg <= data_reg[req_idx][victim];
        end else begin
          mem_addr_reg <= {req_tag, req_idx, {OFF{1'b0}}};
        end
      end
      if (state_reg == WB_REQ && mem_ack_i)
        mem_addr_reg <= {new_tag_reg, vic_idx_reg, {OFF{1'b0}}};
      if (state_reg == RF_REQ && mem_ack_i) begin
        valid_reg[vic_idx_reg][vic_way_reg] <= 1'b1;
        dirty_reg[vic_idx_reg][vic_way_reg] <= 1'b0;
        if (vic_ptr_reg)
          ptr_reg[vic_idx_reg] <= (WAYS == 1) ? '0 : ptr_reg[vic_idx_reg] + 1'b1;
      end
    end
  end

  // Line and tag storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (hit_ok && wr)
        data_reg[req_idx][hit_way][req_word*WORD_W +: WORD_W] <= p1_data_i;
      if (state_reg == RF_REQ && mem_ack_i) begin
        data_reg[vic_idx_reg][vic_way_reg] <= mem_data_i;
        tag_reg[vic_idx_reg][vic_way_reg]  <= new_tag_reg;
      end
    end
  end

  assign p1_data_o    = (hit_ok && rd) ? hit_word : p1_data_reg;
  assign p1_stall_o   = req & (~hit | (state_reg != IDLE));
  assign mem_enable_o = mem_enable_reg;
  assign mem_write_o  = mem_write_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_data_o   = mem_data_reg;
  assign hit_cnt_o    = hit_cnt_reg;
  assign miss_cnt_o   = miss_cnt_reg;
endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: directed scenarios plus randomized traffic against a
// set/way/line reference model and a behavioural line memory.
module tb_dcache_assoc;
  localparam int SETS = 16;
  localparam int WAYS = 2;
  localparam int CMAX = 65535;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  p1_addr = '0, p1_wdata = '0;
  logic         p1_rd = 1'b0, p1_wr = 1'b0;
  logic [31:0]  p1_rdata;
  logic         p1_stall;
  logic [255:0] ack_data = '0;
  logic         ack_auto = 1'b0, ack_man = 1'b0;
  logic         mem_ack;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_addr;
  logic         mem_en, mem_we;
  logic [15:0]  hit_cnt, miss_cnt;

  logic [31:0]  s_addr = '0;
  logic         s_rd = 1'b0;
  logic [31:0]  s_rdata;
  logic         s_stall, s_ack = 1'b0, s_en, s_we;
  logic [255:0] s_line = '0, s_wdata;
  logic [31:0]  s_maddr;
  logic [3:0]   s_hit, s_miss;

  assign mem_ack = ack_auto | ack_man;

  dcache_assoc #(.ADDR_W(32), .WORD_W(32), .LINE_W(256), .SETS(SETS), .WAYS(WAYS), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr), .p1_data_o(p1_rdata), .p1_stall_o(p1_stall),
    .mem_data_i(ack_data), .mem_ack_i(mem_ack), .mem_data_o(mem_wdata), .mem_addr_o(mem_addr),
    .mem_enable_o(mem_en), .mem_write_o(mem_we), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt));

  dcache_assoc #(.ADDR_W(32), .WORD_W(32), .LINE_W(256), .SETS(SETS), .WAYS(WAYS), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst_i), .p1_addr_i(s_addr), .p1_data_i(32'h0),
    .p1_MemRead_i(s_rd), .p1_MemWrite_i(1'b0), .p1_data_o(s_rdata), .p1_stall_o(s_stall),
    .mem_data_i(s_line), .mem_ack_i(s_ack), .mem_data_o(s_wdata), .mem_addr_o(s_maddr),
    .mem_enable_o(s_en), .mem_write_o(s_we), .hit_cnt_o(s_hit), .miss_cnt_o(s_miss));

  always #5 clk = ~clk;

  // Single-cycle acknowledge for the small-counter instance.
  always_ff @(posedge clk) begin
    if (rst_i) s_ack <= 1'b0;
    else       s_ack <= s_en & ~s_ack;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Behavioural memories: one behind the DUT, one inside the reference model.
  logic [255:0] ext_mem [logic [31:0]];
  logic [255:0] ref_mem [logic [31:0]];

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int j = 0; j < 8; j++)
      l[j*32 +: 32] = (la * 32'h9E3779B1) ^ (32'(j) * 32'h01010101) ^ 32'hA5A50000;
    return l;
  endfunction

  function automatic logic [255:0] ext_get(input logic [31:0] la);
    return ext_mem.exists(la) ? ext_mem[la] : init_line(la);
  endfunction

  function automatic logic [255:0] ref_get(input logic [31:0] la);
    return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
  endfunction

  // Memory responder: logs each request and acks it ack_delay cycles later.
  bit           mem_auto = 1'b1;
  int           ack_delay = 2;
  bit           lg_w [$];
  logic [31:0]  lg_a [$];
  logic [255:0] lg_d [$];
  logic         rsp_w;
  logic [31:0]  rsp_a;
  logic [255:0] rsp_d;

  always begin
    @(negedge clk);
    if (mem_auto && mem_en === 1'b1 && !rst_i) begin
      rsp_w = mem_we; rsp_a = mem_addr; rsp_d = mem_wdata;
      lg_w.push_back(rsp_w); lg_a.push_back(rsp_a); lg_d.push_back(rsp_d);
      repeat (ack_delay) @(negedge clk);
      if (rsp_w) ext_mem[rsp_a >> 5] = rsp_d;
      else       ack_data = ext_get(rsp_a >> 5);
      ack_auto = 1'b1;
      @(negedge clk);
      ack_auto = 1'b0;
    end
  end

  // Reference model: sets of ways holding whole lines, memory traffic as a list.
  bit           m_valid [SETS][WAYS];
  bit           m_dirty [SETS][WAYS];
  int unsigned  m_tag   [SETS][WAYS];
  logic [255:0] m_line  [SETS][WAYS];
  int           m_ptr   [SETS];
  int           m_hits, m_misses;
  bit           exp_w [$];
  logic [31:0]  exp_a [$];
  logic [255:0] exp_d [$];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_hits = 0; m_misses = 0;
  endtask

  task automatic model_access(input logic [31:0] a, input bit is_wr, input logic [31:0] wd,
                              output bit hit, output logic [31:0] rword);
    int set, wi, way, v;
    int unsigned tag;
    bit from_ptr;
    logic [31:0] la;
    logic [255:0] ln;
    set = int'((a >> 5) % SETS);
    tag = a >> 9;
    wi  = int'((a >> 2) % 8);
    exp_w.delete(); exp_a.delete(); exp_d.delete();
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set][w] && m_tag[set][w] == tag) way = w;
    hit = (way >= 0);
    if (!hit) begin
      if (m_misses < CMAX) m_misses++;
      v = -1;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[set][w]) v = w;
      from_ptr = (v < 0);
      if (from_ptr) v = m_ptr[set];
      if (m_valid[set][v] && m_dirty[set][v]) begin
        la = (m_tag[set][v] << 9) | (32'(set) << 5);
        exp_w.push_back(1'b1); exp_a.push_back(la); exp_d.push_back(m_line[set][v]);
        ref_mem[la >> 5] = m_line[set][v];
      end
      la = (tag << 9) | (32'(set) << 5);
      exp_w.push_back(1'b0); exp_a.push_back(la); exp_d.push_back('0);
      m_line[set][v]  = ref_get(la >> 5);
      m_valid[set][v] = 1'b1;
      m_dirty[set][v] = 1'b0;
      m_tag[set][v]   = tag;
      if (from_ptr) m_ptr[set] = (m_ptr[set] + 1) % WAYS;
      way = v;
    end
    if (m_hits < CMAX) m_hits++;
    ln = m_line[set][way];
    if (is_wr) begin
      ln[wi*32 +: 32] = wd;
      m_line[set][way] = ln;
      m_dirty[set][way] = 1'b1;
      rword = '0;
    end else begin
      rword = ln[wi*32 +: 32];
    end
  endtask

  task automatic do_req(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] wd, input string tag);
    bit hit;
    logic [31:0] rword;
    int cyc;
    model_access(a, wr, wd, hit, rword);
    lg_w.delete(); lg_a.delete(); lg_d.delete();
    @(negedge clk);
    p1_addr = a; p1_rd = rd; p1_wr = wr; p1_wdata = wd;
    #1;
    check({tag, " stall0"}, p1_stall, !hit);
    cyc = 0;
    if (!hit) begin
      @(negedge clk); #1; cyc = 1;
      check({tag, " mem_en"}, mem_en, 1'b1);
      check({tag, " mem_we"}, mem_we, exp_w.size() == 2);
    end
    while (p1_stall === 1'b1 && cyc < 400) begin
      @(negedge clk); #1; cyc++;
    end
    check({tag, " done"}, cyc < 400, 1'b1);
    if (rd && !wr) check({tag, " rdata"}, p1_rdata, rword);
    @(posedge clk); #1;
    p1_rd = 1'b0; p1_wr = 1'b0;
    check({tag, " mem_idle"}, mem_en, 1'b0);
    check({tag, " nreq"}, lg_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < lg_w.size(); i++) begin
      check({tag, " req_we"}, lg_w[i], exp_w[i]);
      check({tag, " req_addr"}, lg_a[i], exp_a[i]);
      if (exp_w[i]) check({tag, " wb_line"}, lg_d[i], exp_d[i]);
    end
    check({tag, " hit_cnt"}, hit_cnt, m_hits);
    check({tag, " miss_cnt"}, miss_cnt, m_misses);
    $display("txn %-10s addr=%08h rd=%0d wr=%0d hit=%0d mreqs=%0d cycles=%0d", tag, a, rd, wr, hit, lg_w.size(), cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l40;
    logic [31:0]  ra;
    int op, cyc;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_i = 1'b0; #1;
    check("rst p1_data", p1_rdata, 32'h0);
    check("rst stall", p1_stall, 1'b0);
    check("rst mem_en", mem_en, 1'b0);
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_data", mem_wdata, 256'h0);
    check("rst hit_cnt", hit_cnt, 16'h0);
    check("rst miss_cnt", miss_cnt, 16'h0);

    // Load miss with a slow memory, then store/load hits on the resident line.
    l40 = init_line(32'h2);
    l40[31:0] = 32'hDEADBEEF;
    ext_mem[32'h2] = l40;
    ref_mem[32'h2] = l40;
    ack_delay = 10;
    do_req(32'h40, 1'b1, 1'b0, 32'h0, "t1_load");
    check("t1 data", p1_rdata, 32'hDEADBEEF);
    check("t1 hits", hit_cnt, 16'd1);
    check("t1 misses", miss_cnt, 16'd1);
    ack_delay = 3;
    do_req(32'h44, 1'b0, 1'b1, 32'h12345678, "t2_store");
    do_req(32'h44, 1'b1, 1'b0, 32'h0, "t2_load");
    check("t2 data", p1_rdata, 32'h12345678);

    // Conflict set 2: dirty way 0 must be written back, clean way 1 must not.
    do_req(32'h40, 1'b0, 1'b1, 32'hCAFEF00D, "t3_dirty");
    do_req(32'h240, 1'b1, 1'b0, 32'h0, "t3_fill1");
    do_req(32'h440, 1'b1, 1'b0, 32'h0, "t3_evict0");
    if (lg_w.size() == 2) begin
      check("t3 wb_first", lg_w[0], 1'b1);
      check("t3 wb_addr", lg_a[0], 32'h40);
      ra = lg_d[0][31:0];
      check("t3 wb_word0", ra, 32'hCAFEF00D);
      check("t3 rf_addr", lg_a[1], 32'h440);
    end
    do_req(32'h640, 1'b1, 1'b0, 32'h0, "t3_evict1");
    if (lg_w.size() == 1) check("t3 clean_rf", lg_a[0], 32'h640);

    // Read+write together is a store that dirties the line.
    do_req(32'h448, 1'b1, 1'b1, 32'hA5A51234, "t4_rw");
    do_req(32'h448, 1'b1, 1'b0, 32'h0, "t4_load");
    check("t4 data", p1_rdata, 32'hA5A51234);
    do_req(32'h840, 1'b1, 1'b0, 32'h0, "t4_evict");

    for (int t = 0; t < 150; t++) begin
      ra = ($urandom_range(0, 5) << 9) | ($urandom_range(0, 3) << 5) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 3);
      ack_delay = $urandom_range(1, 6);
      do_req(ra, op != 2, op >= 2, $urandom, "rnd");
    end

    // Reset while a refill is outstanding.
    ack_delay = 2;
    do_req(32'h1120, 1'b1, 1'b0, 32'h0, "t5_pre");
    mem_auto = 1'b0;
    @(negedge clk);
    p1_addr = 32'hC920; p1_rd = 1'b1;
    #1;
    check("t5 miss_stall", p1_stall, 1'b1);
    @(negedge clk); #1;
    check("t5 rf_en", mem_en, 1'b1);
    check("t5 rf_we", mem_we, 1'b0);
    check("t5 rf_addr", mem_addr, 32'hC920);
    rst_i = 1'b1; p1_rd = 1'b0;
    @(negedge clk); #1;
    check("t5 en_after_rst", mem_en, 1'b0);
    check("t5 hits_after_rst", hit_cnt, 16'h0);
    check("t5 misses_after_rst", miss_cnt, 16'h0);
    rst_i = 1'b0; ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0; #1;
    check("t5 late_ack_en", mem_en, 1'b0);
    @(negedge clk); #1;
    check("t5 late_ack_en2", mem_en, 1'b0);
    $display("txn t5_reset  aborted refill at %08h", 32'hC920);
    model_reset();
    mem_auto = 1'b1;
    do_req(32'h1120, 1'b1, 1'b0, 32'h0, "t5_remiss");

    // Four-bit counters must stop at 15.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      s_addr = 32'(k) << 9; s_rd = 1'b1;
      #1;
      cyc = 0;
      while (s_stall === 1'b1 && cyc < 50) begin
        @(negedge clk); #1; cyc++;
      end
      check("t6 done", cyc < 50, 1'b1);
      @(posedge clk); #1;
      s_rd = 1'b0;
      check("t6 miss_cnt", s_miss, (k + 1 > 15) ? 15 : k + 1);
      check("t6 hit_cnt", s_hit, (k + 1 > 15) ? 15 : k + 1);
      $display("txn t6_sat    addr=%08h miss_cnt=%0d hit_cnt=%0d", s_addr, s_miss, s_hit);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
